// File: rtl/spike_ack_arbiter.sv
// Round-robin arbiter for level-held spike lines: one-cycle ack to the winner,
// winner index queued in a small event FIFO drained over valid/ready.
module spike_ack_lane (
  input  logic clk,
  input  logic resetn,
  input  logic spike,
  input  logic sel,
  output logic ack,
  output logic elig
);
  logic r_ack;

  always_ff @(posedge clk) begin
    if (!resetn) r_ack <= 1'b0;
    else         r_ack <= sel;
  end

  assign ack  = r_ack;
  // A line still high during its own ack cycle is the old spike, not a new one.
  assign elig = spike & ~r_ack;
endmodule

module spike_ack_arbiter #(
  parameter int N_IN       = 8,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [N_IN-1:0]               spike_in,
  output logic [N_IN-1:0]               ack_out,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [ADDR_W-1:0]             ev_addr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   ev_total
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [N_IN-1:0]   w_elig;
  logic [N_IN-1:0]   w_sel;
  logic              w_found;
  logic              w_grant;
  logic              w_pop;
  logic [ADDR_W-1:0] w_gidx;

  logic [ADDR_W-1:0] r_last;
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [LVL_W-1:0]  r_level;
  logic [15:0]       r_total;
  logic [ADDR_W-1:0] r_mem [FIFO_DEPTH];

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
    spike_ack_lane u_lane (
      .clk    (clk),
      .resetn (resetn),
      .spike  (spike_in[gi]),
      .sel    (w_sel[gi]),
      .ack    (ack_out[gi]),
      .elig   (w_elig[gi])
    );
  end

  // Search from last_grant+1 upward with wrap; first eligible wins.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 1; k <= N_IN; k++) begin
      idx = (int'(r_last) + k) % N_IN;
      if (!w_found && w_elig[idx]) begin
        w_found = 1'b1;
        w_gidx  = ADDR_W'(idx);
      end
    end
  end

  // Full is judged on the pre-edge level: no write-through on a same-edge pop.
  assign w_grant = w_found && (r_level != LVL_W'(FIFO_DEPTH));
  assign w_sel   = w_grant ? (N_IN'(1) << w_gidx) : '0;
  assign w_pop   = ev_valid && ev_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last  <= ADDR_W'(N_IN - 1);
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_total <= '0;
    end else begin
      if (w_grant) begin
        r_last <= w_gidx;
        r_wr   <= r_wr + 1'b1;
        if (r_total != 16'hFFFF) r_total <= r_total + 16'd1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_grant, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && w_grant) r_mem[r_wr] <= w_gidx;
  end

  assign ev_valid   = (r_level != '0);
  assign ev_addr    = ev_valid ? r_mem[r_rd] : '0;
  assign fifo_level = r_level;
  assign ev_total   = r_total;
endmodule

// File: tb/tb_spike_ack_arbiter.sv
// Directed bench for spike_ack_arbiter: one task per scenario, inline checks.
module tb_spike_ack_arbiter;
  logic       clk;
  logic       resetn;
  logic [7:0] spike_in;
  logic [7:0] ack_out;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_addr;
  logic [2:0] fifo_level;
  logic [15:0] ev_total;

  int passed;
  int total;

  spike_ack_arbiter #(.N_IN(8), .ADDR_W(3), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .spike_in   (spike_in),
    .ack_out    (ack_out),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_addr    (ev_addr),
    .fifo_level (fifo_level),
    .ev_total   (ev_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    spike_in = 8'h00;
    ev_ready = 1'b0;
    resetn   = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    total++; if (ack_out !== 8'h00) $display("FAIL reset_ack got %h want 00", ack_out); else passed++;
    total++; if (ev_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ev_valid); else passed++;
    total++; if (ev_addr !== 3'd0) $display("FAIL reset_addr got %0d want 0", ev_addr); else passed++;
    total++; if (fifo_level !== 3'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else passed++;
    total++; if (ev_total !== 16'd0) $display("FAIL reset_total got %0d want 0", ev_total); else passed++;
  endtask

  task automatic test_single();
    spike_in = 8'h04;
    tick();
    total++; if (ack_out !== 8'h04) $display("FAIL single_ack got %h want 04", ack_out); else passed++;
    total++; if (ev_valid !== 1'b1) $display("FAIL single_valid got %b want 1", ev_valid); else passed++;
    total++; if (ev_addr !== 3'd2) $display("FAIL single_addr got %0d want 2", ev_addr); else passed++;
    total++; if (fifo_level !== 3'd1) $display("FAIL single_level got %0d want 1", fifo_level); else passed++;
    total++; if (ev_total !== 16'd1) $display("FAIL single_total got %0d want 1", ev_total); else passed++;
    // spike still held through the ack cycle: must be masked
    tick();
    spike_in = 8'h00;
    total++; if (ack_out !== 8'h00) $display("FAIL single_noreack got %h want 00", ack_out); else passed++;
    total++; if (ev_total !== 16'd1) $display("FAIL single_total2 got %0d want 1", ev_total); else passed++;
    tick();
    total++; if (fifo_level !== 3'd1) $display("FAIL single_level2 got %0d want 1", fifo_level); else passed++;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    total++; if (fifo_level !== 3'd0) $display("FAIL single_drain got %0d want 0", fifo_level); else passed++;
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    spike_in = 8'hFF;
    ev_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp = k % 8;
      total++;
      if (ack_out !== (8'h01 << exp)) $display("FAIL rr_ack[%0d] got %h want %h", k, ack_out, 8'h01 << exp);
      else passed++;
      total++;
      if (ev_addr !== 3'(exp)) $display("FAIL rr_addr[%0d] got %0d want %0d", k, ev_addr, exp);
      else passed++;
    end
    spike_in = 8'h00;
    total++; if (ev_total !== 16'd9) $display("FAIL rr_total got %0d want 9", ev_total); else passed++;
    tick();
    total++; if (fifo_level !== 3'd0) $display("FAIL rr_drain got %0d want 0", fifo_level); else passed++;
    ev_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_ack [4];
    logic [2:0] exp_addr [4];
    exp_ack  = '{8'h02, 8'h08, 8'h20, 8'h40};
    exp_addr = '{3'd3, 3'd5, 3'd6, 3'd7};
    do_reset();
    ev_ready = 1'b0;
    spike_in = 8'hEA;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (ack_out !== exp_ack[k]) $display("FAIL bp_ack[%0d] got %h want %h", k, ack_out, exp_ack[k]);
      else passed++;
      spike_in = spike_in & ~ack_out;
    end
    tick();
    total++; if (ack_out !== 8'h00) $display("FAIL bp_full_ack got %h want 00", ack_out); else passed++;
    total++; if (fifo_level !== 3'd4) $display("FAIL bp_full_level got %0d want 4", fifo_level); else passed++;
    tick();
    total++; if (ack_out !== 8'h00) $display("FAIL bp_hold_ack got %h want 00", ack_out); else passed++;
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    total++; if (ack_out !== 8'h00) $display("FAIL bp_pop_edge_ack got %h want 00", ack_out); else passed++;
    total++; if (fifo_level !== 3'd3) $display("FAIL bp_pop_level got %0d want 3", fifo_level); else passed++;
    tick();
    total++; if (ack_out !== 8'h80) $display("FAIL bp_late_ack got %h want 80", ack_out); else passed++;
    total++; if (fifo_level !== 3'd4) $display("FAIL bp_late_level got %0d want 4", fifo_level); else passed++;
    spike_in = 8'h00;
    ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (ev_addr !== exp_addr[k]) $display("FAIL bp_order[%0d] got %0d want %0d", k, ev_addr, exp_addr[k]);
      else passed++;
      tick();
    end
    ev_ready = 1'b0;
    total++; if (fifo_level !== 3'd0) $display("FAIL bp_drain got %0d want 0", fifo_level); else passed++;
  endtask

  task automatic test_push_pop();
    int pat [12];
    int q [$];
    pat = '{2, 5, 3, 7, 0, 6, 1, 4, 2, 5, 3, 7};
    do_reset();
    ev_ready = 1'b0;
    spike_in = 8'h01;
    tick();
    spike_in = 8'h02;
    tick();
    q = '{0, 1};
    total++; if (fifo_level !== 3'd2) $display("FAIL pp_fill got %0d want 2", fifo_level); else passed++;
    ev_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      spike_in = 8'h01 << pat[k];
      tick();
      void'(q.pop_front());
      q.push_back(pat[k]);
      total++;
      if (fifo_level !== 3'd2) $display("FAIL pp_level[%0d] got %0d want 2", k, fifo_level);
      else passed++;
      total++;
      if (ev_addr !== 3'(q[0])) $display("FAIL pp_head[%0d] got %0d want %0d", k, ev_addr, q[0]);
      else passed++;
    end
    spike_in = 8'h00;
    tick();
    total++; if (ev_addr !== 3'(q[1])) $display("FAIL pp_tail got %0d want %0d", ev_addr, q[1]); else passed++;
    tick();
    ev_ready = 1'b0;
    total++; if (fifo_level !== 3'd0) $display("FAIL pp_drain got %0d want 0", fifo_level); else passed++;
  endtask

  // Ends with 3 entries queued and input 1's ack in flight, feeding test_reset_mid.
  task automatic test_refire();
    do_reset();
    ev_ready = 1'b0;
    spike_in = 8'h01;
    tick();
    total++; if (ack_out !== 8'h01) $display("FAIL rf_ack1 got %h want 01", ack_out); else passed++;
    tick();
    total++; if (ack_out !== 8'h00) $display("FAIL rf_gap got %h want 00", ack_out); else passed++;
    tick();
    total++; if (ack_out !== 8'h01) $display("FAIL rf_ack2 got %h want 01", ack_out); else passed++;
    total++; if (ev_total !== 16'd2) $display("FAIL rf_total got %0d want 2", ev_total); else passed++;
    spike_in = 8'h02;
    tick();
    total++; if (fifo_level !== 3'd3) $display("FAIL rf_level got %0d want 3", fifo_level); else passed++;
  endtask

  task automatic test_reset_mid();
    total++; if (ack_out !== 8'h02) $display("FAIL rm_inflight got %h want 02", ack_out); else passed++;
    spike_in = 8'h81;
    resetn   = 1'b0;
    tick();
    resetn = 1'b1;
    total++; if (ack_out !== 8'h00) $display("FAIL rm_ack got %h want 00", ack_out); else passed++;
    total++; if (ev_valid !== 1'b0) $display("FAIL rm_valid got %b want 0", ev_valid); else passed++;
    total++; if (fifo_level !== 3'd0) $display("FAIL rm_level got %0d want 0", fifo_level); else passed++;
    total++; if (ev_total !== 16'd0) $display("FAIL rm_total got %0d want 0", ev_total); else passed++;
    total++; if (ev_addr !== 3'd0) $display("FAIL rm_addr got %0d want 0", ev_addr); else passed++;
    tick();
    total++; if (ack_out !== 8'h01) $display("FAIL rm_first got %h want 01", ack_out); else passed++;
    spike_in = 8'h00;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    resetn   = 1'b0;
    spike_in = 8'h00;
    ev_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_refire();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
